phase_center_loader: RTL and testbench
======================================

PHASE_CENTER_LOADER -- requirements
Module: phase_center_loader

Interface
REQ-001 Parameter N_CH, default 256: number of channels per stream, power of two.
REQ-002 Parameter PHASE_W, default 16: phase sample and center width, signed two's complement.
REQ-003 user_clk  in  1  single clock for all logic; the register word arrives already in this domain.
REQ-004 user_rst_n  in  1  asynchronous active-low reset.
REQ-005 load_word  in  32  software load_centers register value: [31] load strobe, [23:16] channel, [15:0] center.
REQ-006 sync_in  in  1  frame start pulse; the phase_in sample in the same cycle is channel 0.
REQ-007 phase_in  in  PHASE_W  input phase sample.
REQ-008 phase_in_vld  in  1  phase_in qualifier.
REQ-009 phase_out  out  PHASE_W  centered phase, equal to phase_in minus center[ch].
REQ-010 phase_out_vld  out  1  phase_out qualifier.
REQ-011 ch_out  out  log2(N_CH)  channel index of phase_out.
REQ-012 ready  out  1  high once table clear completes.
REQ-013 load_ack  out  1  one-cycle pulse per committed center write.
REQ-014 load_count  out  16  count of committed writes, wraps 0xFFFF->0.

Function
REQ-015 FSM states CLEAR and RUN; the FSM SHALL enter CLEAR on reset and SHALL write 0 to entries 0..N_CH-1, one per cycle, then enter RUN.
REQ-016 ready SHALL be 0 in CLEAR and 1 in RUN; no other transition exists.
REQ-017 Load detection: a rising edge of load_word[31], registered against its previous value, SHALL set a pending flag that latches channel and center.
REQ-018 In RUN, a pending write SHALL commit on the cycle after detection, assert load_ack for 1 cycle, increment load_count and clear pending.
REQ-019 A rising edge during CLEAR SHALL stay pending and commit on the first RUN cycle.
REQ-020 A second rising edge while pending SHALL overwrite the latched channel and center, yielding one commit only.
REQ-021 Channel bits above log2(N_CH)-1 SHALL be ignored, so the address wraps modulo N_CH.
REQ-022 Channel counter: sync_in&phase_in_vld sets ch to 0; otherwise each phase_in_vld increments ch, wrapping N_CH-1->0.
REQ-023 phase_in_vld without any prior sync_in SHALL still count from 0 after reset.
REQ-024 Datapath latency SHALL be exactly 2 cycles from phase_in_vld to phase_out_vld, with ch_out aligned to it.
REQ-025 Subtraction SHALL be modulo 2^PHASE_W with wrap-around and no saturation.
REQ-026 A write commit to the same channel in the same cycle as its table read SHALL return the old center; the new value applies from the next read.
REQ-027 In CLEAR, phase_out_vld SHALL be 0 and input samples SHALL be discarded; the channel counter SHALL still advance.

Reset
REQ-028 Asserting user_rst_n low SHALL asynchronously clear these outputs and state: phase_out, phase_out_vld, ch_out, ready, load_ack, load_count, pending flag, prior strobe bit (0), and FSM (CLEAR, clear address 0).
REQ-029 Reset mid-RUN SHALL discard pending writes and in-flight samples, and the table SHALL be re-cleared.
REQ-030 Deassertion SHALL be synchronized to user_clk by the parent; the block SHALL contain no internal reset synchronizer.

Structure
REQ-031 Shared package SHALL hold N_CH, PHASE_W, the load_word field bit positions and the FSM state typedef.
REQ-032 One sub-module, center_ram: simple dual-port N_CH x PHASE_W RAM with 1-cycle registered read and read-old-on-collision behaviour; the FSM, edge detection, counter and subtractor stay in the top module.

Verification
REQ-033 Reset, then idle: ready rises exactly N_CH cycles after reset release; phase_in 0x1234 on ch5 -> phase_out 0x1234.
REQ-034 load_word 0x0005_0100 then 0x8005_0100 -> load_ack 1 cycle, load_count 1; ch5 sample 0x0300 -> 0x0200, ch6 unchanged.
REQ-035 Center 0x7FFF on ch0, sample 0x8000 -> phase_out 0x0001; center 0xFFFF, sample 0x7FFF -> 0x8000.
REQ-036 Strobe toggled twice during CLEAR with channels 3 then 4, center 0x0010 -> single commit to ch4 on first RUN cycle, load_count 1.
REQ-037 Write ch9 coinciding with ch9 read -> that sample uses old center; the next frame's ch9 sample uses new center.
REQ-038 Continuous vld for 300 cycles with sync at cycle 0 only -> ch_out wraps 255->0 at sample 256; user_rst_n pulsed mid-stream -> outputs 0 and ready 0 for N_CH cycles.

Source files
------------

// File: rtl/phase_center_loader_pkg.sv
// ----------------------------------------------------------------------------
// phase_center_loader_pkg
// Shared definitions for the phase centering block: default geometry, the
// bit layout of the software load_centers register word, the width of the
// commit counter and the FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package phase_center_loader_pkg;

    // Default geometry: channels per stream (power of two) and phase width
    localparam int N_CH_DEF    = 256;
    localparam int PHASE_W_DEF = 16;

    // load_centers register word layout
    localparam int LOAD_STROBE_BIT = 31;
    localparam int LOAD_CH_MSB     = 23;
    localparam int LOAD_CH_LSB     = 16;
    localparam int LOAD_CENTER_MSB = 15;
    localparam int LOAD_CENTER_LSB = 0;
    localparam int LOAD_WORD_W     = 32;

    // Committed-write counter width (wraps 0xFFFF -> 0)
    localparam int LOAD_COUNT_W = 16;

    // CLEAR wipes the center table after reset, RUN is normal operation
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/phase_center_loader_if.sv
// ----------------------------------------------------------------------------
// phase_center_loader_if
// Bundles the register word, the phase input stream and the centered phase
// output stream of phase_center_loader.
//   master : drives load_word, sync_in, phase_in, phase_in_vld;
//            observes phase_out, phase_out_vld, ch_out, ready, load_ack,
//            load_count
//   slave  : the centering block (mirror image of master)
// ----------------------------------------------------------------------------
interface phase_center_loader_if
    import phase_center_loader_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int PHASE_W = PHASE_W_DEF
);
    localparam int CH_W = $clog2(N_CH);

    logic [LOAD_WORD_W-1:0]  load_word;
    logic                    sync_in;
    logic [PHASE_W-1:0]      phase_in;
    logic                    phase_in_vld;

    logic [PHASE_W-1:0]      phase_out;
    logic                    phase_out_vld;
    logic [CH_W-1:0]         ch_out;
    logic                    ready;
    logic                    load_ack;
    logic [LOAD_COUNT_W-1:0] load_count;

    modport master (
        output load_word, sync_in, phase_in, phase_in_vld,
        input  phase_out, phase_out_vld, ch_out, ready, load_ack, load_count
    );

    modport slave (
        input  load_word, sync_in, phase_in, phase_in_vld,
        output phase_out, phase_out_vld, ch_out, ready, load_ack, load_count
    );

endinterface

// File: rtl/phase_center_loader_center_ram.sv
// ----------------------------------------------------------------------------
// center_ram
// Simple dual-port DEPTH x WIDTH table holding one phase center per channel.
// Read data is registered (one cycle latency). When the write and the read
// hit the same address in the same cycle the read returns the old contents.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : registered read data
// ----------------------------------------------------------------------------
module center_ram #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Both the write and the registered read sample mem_q before this edge's
    // update, which gives read-old on an address collision. No reset: the
    // top clears the contents through the write port after every reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/phase_center_loader.sv
// ----------------------------------------------------------------------------
// phase_center_loader
// Subtracts a per-channel phase center from an incoming phase stream. The
// centers live in a table that is zeroed after reset and then updated by
// software through the load_centers register word (rising edge of the
// strobe bit commits one channel/center pair).
// Ports:
//   user_clk   : single clock for all logic
//   user_rst_n : asynchronous active-low reset (deassertion synchronized
//                by the parent)
//   pcl_s      : slave side of phase_center_loader_if
//                load_word, sync_in, phase_in, phase_in_vld in;
//                phase_out, phase_out_vld, ch_out, ready, load_ack,
//                load_count out
// ----------------------------------------------------------------------------
module phase_center_loader
    import phase_center_loader_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    phase_center_loader_if.slave pcl_s
);

    localparam int              CH_W    = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         clr_addr_q, clr_addr_d;

    logic                    strobe_prev_q;
    logic                    pend_q, pend_d;
    logic [CH_W-1:0]         pend_ch_q, pend_ch_d;
    logic [PHASE_W-1:0]      pend_ctr_q, pend_ctr_d;
    logic                    load_ack_q, load_ack_d;
    logic [LOAD_COUNT_W-1:0] load_count_q, load_count_d;

    logic [CH_W-1:0]         ch_q, ch_d, ch_cur;

    logic                    s1_vld_q;
    logic [CH_W-1:0]         s1_ch_q;
    logic [PHASE_W-1:0]      s1_phase_q;
    logic                    out_vld_q;
    logic [CH_W-1:0]         out_ch_q;
    logic [PHASE_W-1:0]      out_phase_q;

    logic                    ram_we;
    logic [CH_W-1:0]         ram_waddr;
    logic [PHASE_W-1:0]      ram_wdata;
    logic [PHASE_W-1:0]      ram_rdata;

    logic                    running;
    logic                    strobe;
    logic                    load_rise;
    logic                    commit;
    logic [CH_W-1:0]         word_ch;
    logic [PHASE_W-1:0]      word_ctr;
    logic                    unused_load_bits;

    // Register word fields; channel bits above CH_W-1 are dropped so the
    // address wraps modulo N_CH.
    assign strobe           = pcl_s.load_word[LOAD_STROBE_BIT];
    assign word_ch          = pcl_s.load_word[LOAD_CH_LSB +: CH_W];
    assign word_ctr         = pcl_s.load_word[LOAD_CENTER_LSB +: PHASE_W];
    assign unused_load_bits = ^pcl_s.load_word;

    assign running   = (state_q == ST_RUN);
    assign load_rise = strobe && !strobe_prev_q;
    assign commit    = pend_q && running;

    // FSM state register and clear address
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // FSM next state and table write port: CLEAR writes zero to one entry
    // per cycle and leaves after the last one; RUN only ever writes pending
    // center loads and never leaves.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_waddr  = pend_ch_q;
        ram_wdata  = pend_ctr_q;
        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + CH_W'(1);
                if (clr_addr_q == LAST_CH) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_we = commit;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Load path next state. A new rising edge always (re)latches the pair,
    // so a second edge before commit overwrites the first and a pending load
    // simply waits through CLEAR until the first RUN cycle.
    always_comb begin
        pend_d       = pend_q;
        pend_ch_d    = pend_ch_q;
        pend_ctr_d   = pend_ctr_q;
        load_ack_d   = commit;
        load_count_d = load_count_q;
        if (commit) begin
            pend_d       = 1'b0;
            load_count_d = load_count_q + LOAD_COUNT_W'(1);
        end
        if (load_rise) begin
            pend_d     = 1'b1;
            pend_ch_d  = word_ch;
            pend_ctr_d = word_ctr;
        end
    end

    // Load path registers
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            strobe_prev_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_ch_q     <= '0;
            pend_ctr_q    <= '0;
            load_ack_q    <= 1'b0;
            load_count_q  <= '0;
        end else begin
            strobe_prev_q <= strobe;
            pend_q        <= pend_d;
            pend_ch_q     <= pend_ch_d;
            pend_ctr_q    <= pend_ctr_d;
            load_ack_q    <= load_ack_d;
            load_count_q  <= load_count_d;
        end
    end

    // Channel of the current sample: sync forces channel 0, otherwise the
    // running count. The counter advances even in CLEAR so channel alignment
    // survives the table wipe.
    always_comb begin
        ch_cur = pcl_s.sync_in ? '0 : ch_q;
        ch_d   = ch_q;
        if (pcl_s.phase_in_vld) begin
            ch_d = ch_cur + CH_W'(1);
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    // Two-stage datapath: stage 1 waits for the table read, stage 2 holds
    // the wrapping difference. Samples arriving in CLEAR never become valid.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_phase_q  <= '0;
            out_vld_q   <= 1'b0;
            out_ch_q    <= '0;
            out_phase_q <= '0;
        end else begin
            s1_vld_q    <= pcl_s.phase_in_vld && running;
            s1_ch_q     <= ch_cur;
            s1_phase_q  <= pcl_s.phase_in;
            out_vld_q   <= s1_vld_q;
            out_ch_q    <= s1_ch_q;
            out_phase_q <= s1_phase_q - ram_rdata;
        end
    end

    center_ram #(
        .DEPTH (N_CH),
        .WIDTH (PHASE_W),
        .ADDR_W(CH_W)
    ) u_center_ram (
        .clk_i  (user_clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(ch_cur),
        .rdata_o(ram_rdata)
    );

    assign pcl_s.phase_out     = out_phase_q;
    assign pcl_s.phase_out_vld = out_vld_q;
    assign pcl_s.ch_out        = out_ch_q;
    assign pcl_s.ready         = running;
    assign pcl_s.load_ack      = load_ack_q;
    assign pcl_s.load_count    = load_count_q;

endmodule

// File: tb/tb_phase_center_loader.sv
// ----------------------------------------------------------------------------
// tb_phase_center_loader
// Self-checking bench for phase_center_loader. Each driven sample pushes its
// expected phase, channel and arrival cycle into a scoreboard queue; a
// monitor pops and compares whenever phase_out_vld is seen.
// No ports (top-level bench).
// ----------------------------------------------------------------------------
module tb_phase_center_loader;

    localparam int N_CH    = 256;
    localparam int PHASE_W = 16;

    typedef struct {
        logic [PHASE_W-1:0] phase;
        int                 ch;
        int                 cyc;
    } exp_t;

    logic user_clk;
    logic user_rst_n;

    phase_center_loader_if #(.N_CH(N_CH), .PHASE_W(PHASE_W)) bus ();

    phase_center_loader #(
        .N_CH   (N_CH),
        .PHASE_W(PHASE_W)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .pcl_s     (bus)
    );

    exp_t               sbQ[$];
    logic [PHASE_W-1:0] centers[N_CH];
    int                 cycleCnt     = 0;
    int                 numCompared  = 0;
    int                 numMismatch  = 0;
    int                 expLoadCount = 0;

    // 100 MHz clock
    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    // Cycle counter used to check the exact output latency
    always @(posedge user_clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     tag, observed, expected, cycleCnt);
        end
    endtask

    // Monitor: every valid output must match the oldest scoreboard entry
    always @(negedge user_clk) begin
        if (user_rst_n && bus.phase_out_vld) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedOut", 32'(bus.ch_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("phaseOut", 32'(bus.phase_out), 32'(e.phase));
                checkOutput("chOut", 32'(bus.ch_out), 32'(e.ch));
                checkOutput("latency", 32'(cycleCnt), 32'(e.cyc));
            end
        end
    end

    // Drive one valid sample for one cycle and queue its expected result
    task automatic applyStimulus(input logic sync, input logic [PHASE_W-1:0] ph,
                                 input int expCh, input logic [PHASE_W-1:0] expPh);
        exp_t e;
        @(posedge user_clk); #1;
        bus.sync_in      = sync;
        bus.phase_in     = ph;
        bus.phase_in_vld = 1'b1;
        e.phase = expPh;
        e.ch    = expCh;
        e.cyc   = cycleCnt + 2;
        sbQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge user_clk); #1;
            bus.sync_in      = 1'b0;
            bus.phase_in_vld = 1'b0;
        end
    endtask

    // Write one center through a strobe rising edge and verify the ack pulse
    task automatic loadCenter(input logic [7:0] ch, input logic [15:0] ctr);
        int acks;
        acks = 0;
        @(posedge user_clk); #1;
        bus.sync_in      = 1'b0;
        bus.phase_in_vld = 1'b0;
        bus.load_word    = {8'h00, ch, ctr};
        @(posedge user_clk); #1;
        bus.load_word[31] = 1'b1;
        repeat (6) begin
            @(posedge user_clk); #1;
            if (bus.load_ack) acks++;
        end
        bus.load_word[31] = 1'b0;
        centers[ch] = ctr;
        expLoadCount++;
        checkOutput("loadAckPulse", 32'(acks), 32'd1);
        checkOutput("loadCount", 32'(bus.load_count), 32'(expLoadCount));
    endtask

    // Assert reset mid-cycle, check cleared outputs, then release
    task automatic doReset();
        @(negedge user_clk); #2;
        user_rst_n       = 1'b0;
        bus.phase_in_vld = 1'b0;
        bus.sync_in      = 1'b0;
        bus.load_word    = '0;
        sbQ.delete();
        for (int i = 0; i < N_CH; i++) centers[i] = '0;
        expLoadCount = 0;
        #1;
        checkOutput("rstPhaseOut", 32'(bus.phase_out), 32'd0);
        checkOutput("rstPhaseVld", 32'(bus.phase_out_vld), 32'd0);
        checkOutput("rstChOut", 32'(bus.ch_out), 32'd0);
        checkOutput("rstReady", 32'(bus.ready), 32'd0);
        checkOutput("rstLoadAck", 32'(bus.load_ack), 32'd0);
        checkOutput("rstLoadCount", 32'(bus.load_count), 32'd0);
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        user_rst_n = 1'b1;
    endtask

    // Count cycles from reset release until ready, with a bound
    task automatic waitReady(output int n, output int acks);
        n    = 0;
        acks = 0;
        while (!bus.ready && n < 4 * N_CH) begin
            @(posedge user_clk); #1;
            n++;
            if (bus.load_ack) acks++;
        end
    endtask

    // Global time limit
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int acks;
        int readyAt;
        int ackAt;
        int ackCnt;
        logic [PHASE_W-1:0] ph;

        user_rst_n       = 1'b0;
        bus.load_word    = '0;
        bus.sync_in      = 1'b0;
        bus.phase_in     = '0;
        bus.phase_in_vld = 1'b0;

        // Reset, table clear takes exactly N_CH cycles, zero centers
        doReset();
        waitReady(n, acks);
        checkOutput("readyDelay", 32'(n), 32'(N_CH));
        for (int i = 0; i < 6; i++) begin
            ph = (i == 5) ? 16'h1234 : 16'(i * 16'h0111);
            applyStimulus(i == 0, ph, i, ph);
        end
        idle(4);

        // Plain word then strobed word loads ch5 = 0x0100
        bus.load_word = 32'h0005_0100;
        idle(3);
        checkOutput("noLoadWithoutStrobe", 32'(bus.load_count), 32'd0);
        loadCenter(8'd5, 16'h0100);
        for (int i = 0; i < 5; i++) applyStimulus(i == 0, 16'h0300, i, 16'h0300);
        applyStimulus(1'b0, 16'h0300, 5, 16'h0200);
        applyStimulus(1'b0, 16'h0300, 6, 16'h0300);
        idle(4);

        // Wrap-around subtraction
        loadCenter(8'd0, 16'h7FFF);
        loadCenter(8'd1, 16'hFFFF);
        applyStimulus(1'b1, 16'h8000, 0, 16'h0001);
        applyStimulus(1'b0, 16'h7FFF, 1, 16'h8000);
        idle(4);

        // Commit to ch9 lands in the same cycle as the ch9 read
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i == 0, 16'h1000, i, 16'(16'h1000 - centers[i]));
            if (i == 8) bus.load_word = 32'h8009_0040;
        end
        applyStimulus(1'b0, 16'h1000, 9, 16'h1000);
        idle(3);
        bus.load_word[31] = 1'b0;
        centers[9] = 16'h0040;
        expLoadCount++;
        checkOutput("loadCountCollide", 32'(bus.load_count), 32'(expLoadCount));
        for (int i = 0; i < 9; i++) applyStimulus(i == 0, 16'h1000, i, 16'(16'h1000 - centers[i]));
        applyStimulus(1'b0, 16'h1000, 9, 16'h0FC0);
        idle(4);

        // Two strobe edges during CLEAR, plus samples discarded in CLEAR
        doReset();
        readyAt = -1;
        ackAt   = -1;
        ackCnt  = 0;
        for (int i = 1; i <= N_CH + 4; i++) begin
            @(posedge user_clk); #1;
            if (bus.ready && readyAt < 0) readyAt = i;
            if (bus.load_ack) begin
                ackCnt++;
                if (ackAt < 0) ackAt = i;
            end
            case (i)
                10: bus.load_word = 32'h8003_0010;
                12: bus.load_word = 32'h0004_0010;
                14: bus.load_word = 32'h8004_0010;
                16: bus.load_word = 32'h0004_0010;
                default: ;
            endcase
            bus.phase_in     = 16'h5555;
            bus.phase_in_vld = (i >= 20 && i < 25);
        end
        bus.phase_in_vld = 1'b0;
        centers[4]   = 16'h0010;
        expLoadCount = 1;
        checkOutput("readyDelayClr", 32'(readyAt), 32'(N_CH));
        checkOutput("ackFirstRun", 32'(ackAt), 32'(N_CH + 1));
        checkOutput("ackCountClr", 32'(ackCnt), 32'd1);
        checkOutput("loadCountClr", 32'(bus.load_count), 32'd1);
        applyStimulus(1'b0, 16'h0100, 5, 16'h0100);
        for (int i = 0; i < 3; i++) applyStimulus(i == 0, 16'h0100, i, 16'h0100);
        applyStimulus(1'b0, 16'h0100, 3, 16'h0100);
        applyStimulus(1'b0, 16'h0100, 4, 16'h00F0);
        idle(4);

        // Continuous stream, single sync, channel wraps at sample 256
        for (int i = 0; i < 300; i++) begin
            ph = 16'($urandom);
            applyStimulus(i == 0, ph, i % N_CH, 16'(ph - centers[i % N_CH]));
        end

        // Pending load and in-flight samples are dropped by a mid-run reset
        bus.load_word = 32'h8007_0777;
        @(posedge user_clk);
        doReset();
        waitReady(n, acks);
        checkOutput("readyDelayMid", 32'(n), 32'(N_CH));
        checkOutput("ackAfterMidReset", 32'(acks), 32'd0);
        checkOutput("loadCountMid", 32'(bus.load_count), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(i == 0, 16'h0777, i, 16'h0777);
        applyStimulus(1'b0, 16'h0777, 7, 16'h0777);
        idle(6);

        checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatch);
        $finish;
    end

endmodule
